data_2048x8_ctrl: RTL and testbench
===================================

DATA_2048X8_CTRL -- requirements
Module: data_2048x8_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning memory address width (2048 words).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning memory word width.
REQ-003 The block SHALL have parameter MASK_W, default 4, meaning write-mask granules of DATA_W/MASK_W bits each.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high; the ports are named clock and reset.
REQ-005 The block SHALL have these ports:
- clock  in  1  sole clock; also drives memory R0_clk and W0_clk
- reset  in  1  synchronous, active-high
- clr_start  in  1  pulse that requests a full memory clear
- busy  out  1  high while a clear is in progress
- c0_valid, c1_valid  in  1  client request valid
- c0_ready, c1_ready  out  1  client request accepted this cycle
- c0_we, c1_we  in  1  1 = write, 0 = read
- c0_addr, c1_addr  in  ADDR_W  request address
- c0_wdata, c1_wdata  in  DATA_W  write data
- c0_wmask, c1_wmask  in  MASK_W  write granule enables
- c0_rvalid, c1_rvalid  out  1  read data valid
- c0_rdata, c1_rdata  out  DATA_W  read data
- m_R0_addr  out  ADDR_W  memory read address
- m_R0_en  out  1  memory read enable
- m_R0_data  in  DATA_W  memory read data
- m_W0_addr  out  ADDR_W  memory write address
- m_W0_en  out  1  memory write enable
- m_W0_data  out  DATA_W  memory write data
- m_W0_mask  out  MASK_W  memory write mask

Function
REQ-006 The FSM SHALL have states CLEAR and RUN; it SHALL enter CLEAR on reset and enter CLEAR from RUN when clr_start=1.
REQ-007 In CLEAR, the block SHALL write data 0 with mask all-ones to addresses 0..2047 in ascending order, one address per cycle, using an ADDR_W-bit counter.
REQ-008 After writing address 2047, the block SHALL enter RUN on the next cycle; a CLEAR sequence therefore lasts exactly 2048 cycles.
REQ-009 clr_start SHALL be ignored while in CLEAR.
REQ-010 busy SHALL equal (state==CLEAR); in CLEAR, c0_ready and c1_ready SHALL be 0.
REQ-011 In RUN, the block SHALL grant at most one request per cycle; ready SHALL be combinational from valid and the priority bit; a request is accepted when valid&&ready.
REQ-012 Arbitration SHALL be round-robin: the priority bit toggles to favour the other client after each grant; it resets to favour client 0.
REQ-013 A sole valid client SHALL be granted regardless of the priority bit.
REQ-014 An accepted write SHALL drive m_W0_en=1, with m_W0_addr, m_W0_data and m_W0_mask taken from the granted client, in the same cycle.
REQ-015 An accepted read SHALL drive m_R0_en=1 and m_R0_addr in the same cycle.
REQ-016 For an accepted read, the requesting client's rvalid SHALL pulse high for exactly one cycle, one cycle after acceptance, with rdata=m_R0_data.
REQ-017 The read-response owner SHALL be held in a 1-bit registered tag.
REQ-018 The non-owner's rvalid SHALL be 0; rdata SHALL be driven from m_R0_data to both clients.
REQ-019 m_R0_en and m_W0_en SHALL never both be 1 in the same cycle.
REQ-020 When no grant or clear write is active, m_R0_en=0 and m_W0_en=0.
REQ-021 If clr_start=1 and a request is accepted in the same cycle, the request SHALL complete, including its read response in the next cycle; CLEAR begins on the following cycle.

Reset
REQ-022 On reset, the block SHALL set state=CLEAR, clear counter=0, priority=client 0, response tag=0, and both rvalid outputs=0.
REQ-023 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-024 Reset asserted mid-RUN SHALL drop any pending read response (rvalid=0 in the next cycle).
REQ-025 Outputs in the first cycle after reset SHALL be busy=1, m_W0_en=1, m_W0_addr=0.

Structure
REQ-026 A shared package data_2048x8_ctrl_pkg SHALL hold the state enum (CLEAR, RUN) and the constants ADDR_W, DATA_W, MASK_W and DEPTH=2048.
REQ-027 One sub-module, data_2048x8_rr_arb (2-way round-robin arbiter: valids in, grants out, priority register), SHALL be instantiated; the rest of the block is flat.

Verification
REQ-028 Scenario: release reset and count cycles -> busy is high for exactly 2048 cycles, m_W0_addr steps 0..2047 with data 0 and mask 0xF, and the ready outputs are 0 throughout.
REQ-029 Scenario: c0 writes addr 0x155, data 0xA5, mask 0xF, then c0 reads 0x155 -> c0_rvalid is high one cycle after acceptance with c0_rdata=0xA5, and c1_rvalid stays 0.
REQ-030 Scenario: c0 and c1 hold valid continuously for 6 cycles -> grants go c0,c1,c0,c1,c0,c1.
REQ-031 Scenario: write addr 7 with data 0xFF, mask 0xF, then write addr 7 with data 0x00, mask 0x5, then read addr 7 -> rdata=0xCC.
REQ-032 Scenario: clr_start pulses in RUN in the same cycle c1 reads addr 3 -> c1_rvalid pulses next cycle, busy rises the following cycle, and the clear lasts 2048 cycles.
REQ-033 Scenario: reset pulses at clear address 1000 -> the clear restarts at address 0 and busy stays high for 2048 more cycles.

Source files
------------

// File: rtl/data_2048x8_ctrl_pkg.sv
// data_2048x8_ctrl_pkg: shared constants and FSM state type for the memory controller.
package data_2048x8_ctrl_pkg;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int MASK_W = 4;
    localparam int DEPTH  = 2048;
    typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/data_2048x8_rr_arb.sv
// data_2048x8_rr_arb: 2-way round-robin arbiter; after a grant the other client is favoured.
module data_2048x8_rr_arb (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic prio;
    always_comb grant = (&valid) ? (prio ? 2'b10 : 2'b01) : valid;
    always_ff @(posedge clock) begin
        if (reset) prio <= 1'b0;
        else if (|grant) prio <= grant[0];
    end
endmodule

// File: rtl/data_2048x8_ctrl.sv
// data_2048x8_ctrl: two-client front end for a 1R1W memory with a power-on/on-demand clear sweep.
module data_2048x8_ctrl #(
    parameter int ADDR_W = data_2048x8_ctrl_pkg::ADDR_W,
    parameter int DATA_W = data_2048x8_ctrl_pkg::DATA_W,
    parameter int MASK_W = data_2048x8_ctrl_pkg::MASK_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_start,
    output logic              busy,
    input  logic              c0_valid,
    input  logic              c1_valid,
    output logic              c0_ready,
    output logic              c1_ready,
    input  logic              c0_we,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic [DATA_W-1:0] c1_wdata,
    input  logic [MASK_W-1:0] c0_wmask,
    input  logic [MASK_W-1:0] c1_wmask,
    output logic              c0_rvalid,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c0_rdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic [ADDR_W-1:0] m_R0_addr,
    output logic              m_R0_en,
    input  logic [DATA_W-1:0] m_R0_data,
    output logic [ADDR_W-1:0] m_W0_addr,
    output logic              m_W0_en,
    output logic [DATA_W-1:0] m_W0_data,
    output logic [MASK_W-1:0] m_W0_mask
);
    import data_2048x8_ctrl_pkg::*;

    state_t state, state_n;
    logic [ADDR_W-1:0] cnt;
    logic [1:0] grant;
    logic run, acc, we, rv, tag;
    logic [ADDR_W-1:0] addr;

    assign run = (state == RUN);

    data_2048x8_rr_arb u_arb (
        .clock(clock),
        .reset(reset),
        .valid({c1_valid, c0_valid} & {2{run}}),
        .grant(grant)
    );

    always_comb begin
        acc       = |grant;
        we        = grant[1] ? c1_we : c0_we;
        addr      = grant[1] ? c1_addr : c0_addr;
        state_n   = run ? (clr_start ? CLEAR : RUN) : (&cnt ? RUN : CLEAR);
        busy      = !run;
        c0_ready  = grant[0];
        c1_ready  = grant[1];
        m_R0_en   = acc && !we;
        m_R0_addr = addr;
        // The clear sweep owns the write port whenever the FSM is not in RUN.
        m_W0_en   = !run || (acc && we);
        m_W0_addr = run ? addr : cnt;
        m_W0_data = run ? (grant[1] ? c1_wdata : c0_wdata) : '0;
        m_W0_mask = run ? (grant[1] ? c1_wmask : c0_wmask) : '1;
        c0_rvalid = rv && !tag;
        c1_rvalid = rv && tag;
        c0_rdata  = m_R0_data;
        c1_rdata  = m_R0_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
            rv    <= 1'b0;
            tag   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= run ? '0 : cnt + ADDR_W'(1);
            rv    <= m_R0_en;
            tag   <= grant[1];
        end
    end
endmodule

// File: tb/tb_data_2048x8_ctrl.sv
// tb_data_2048x8_ctrl: directed and random checks of data_2048x8_ctrl against a memory-level reference model.
module tb_data_2048x8_ctrl;
    import data_2048x8_ctrl_pkg::*;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [10:0] a;
        logic [7:0]  d;
        logic [3:0]  m;
    } req_t;

    logic clock, reset, clr_start, busy;
    logic c0_valid, c1_valid, c0_ready, c1_ready, c0_we, c1_we;
    logic [10:0] c0_addr, c1_addr, m_R0_addr, m_W0_addr;
    logic [7:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata, m_R0_data, m_W0_data;
    logic [3:0] c0_wmask, c1_wmask, m_W0_mask;
    logic c0_rvalid, c1_rvalid, m_R0_en, m_W0_en;

    data_2048x8_ctrl dut (
        .clock(clock), .reset(reset), .clr_start(clr_start), .busy(busy),
        .c0_valid(c0_valid), .c1_valid(c1_valid), .c0_ready(c0_ready), .c1_ready(c1_ready),
        .c0_we(c0_we), .c1_we(c1_we), .c0_addr(c0_addr), .c1_addr(c1_addr),
        .c0_wdata(c0_wdata), .c1_wdata(c1_wdata), .c0_wmask(c0_wmask), .c1_wmask(c1_wmask),
        .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid), .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
        .m_R0_addr(m_R0_addr), .m_R0_en(m_R0_en), .m_R0_data(m_R0_data),
        .m_W0_addr(m_W0_addr), .m_W0_en(m_W0_en), .m_W0_data(m_W0_data), .m_W0_mask(m_W0_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] apply(input logic [7:0] old, input logic [7:0] d, input logic [3:0] m);
        logic [7:0] r;
        r = old;
        for (int g = 0; g < 4; g++) if (m[g]) r[g*2 +: 2] = d[g*2 +: 2];
        return r;
    endfunction

    // Memory macro stand-in: one-cycle read latency, masked writes.
    logic [7:0] mem [DEPTH];
    always @(posedge clock) begin
        if (m_R0_en) m_R0_data <= mem[m_R0_addr];
        if (m_W0_en) mem[m_W0_addr] = apply(mem[m_W0_addr], m_W0_data, m_W0_mask);
    end

    logic [7:0] ref_mem [DEPTH];
    logic prio, pend, pend_own;
    logic [7:0] pend_data;
    int passes = 0, fails = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic v, input logic we, input logic [10:0] a, input logic [7:0] d, input logic [3:0] m);
        req_t r;
        r.v = v; r.we = we; r.a = a; r.d = d; r.m = m;
        return r;
    endfunction

    function automatic req_t rnd();
        return mk(1'($urandom), 1'($urandom), 11'($urandom_range(0, 15)), 8'($urandom), 4'($urandom));
    endfunction

    task automatic drive(input req_t r0, input req_t r1, input logic clr);
        c0_valid = r0.v; c0_we = r0.we; c0_addr = r0.a; c0_wdata = r0.d; c0_wmask = r0.m;
        c1_valid = r1.v; c1_we = r1.we; c1_addr = r1.a; c1_wdata = r1.d; c1_wmask = r1.m;
        clr_start = clr;
    endtask

    task automatic check_resp();
        chk("c0_rvalid", c0_rvalid, pend && !pend_own);
        chk("c1_rvalid", c1_rvalid, pend && pend_own);
        if (pend) chk("rdata", pend_own ? c1_rdata : c0_rdata, pend_data);
    endtask

    // Entered and left at a falling edge; checks one clear cycle per address.
    task automatic check_clear(input int n);
        for (int i = 0; i < n; i++) begin
            drive(rnd(), rnd(), 1'($urandom));
            #1;
            check_resp();
            pend = 1'b0;
            chk("clear", {busy, m_W0_en, m_W0_addr, m_W0_data, m_W0_mask, c0_ready, c1_ready, m_R0_en},
                {1'b1, 1'b1, i[10:0], 8'h00, 4'hF, 3'b000});
            ref_mem[i] = 8'h00;
            @(negedge clock);
        end
        drive(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 1'b0);
    endtask

    task automatic run_cycle(input req_t r0, input req_t r1, input logic clr, output logic g);
        req_t r;
        logic gv;
        drive(r0, r1, clr);
        #1;
        check_resp();
        gv = r0.v || r1.v;
        g  = (r0.v && r1.v) ? prio : r1.v;
        r  = g ? r1 : r0;
        chk("busy", busy, 1'b0);
        chk("c0_ready", c0_ready, gv && !g);
        chk("c1_ready", c1_ready, gv && g);
        chk("ports_en", {m_R0_en, m_W0_en}, {gv && !r.we, gv && r.we});
        if (gv && r.we) chk("w_port", {m_W0_addr, m_W0_data, m_W0_mask}, {r.a, r.d, r.m});
        if (gv && !r.we) chk("r_addr", m_R0_addr, r.a);
        pend = gv && !r.we;
        pend_own = g;
        pend_data = ref_mem[r.a];
        if (gv && r.we) ref_mem[r.a] = apply(ref_mem[r.a], r.d, r.m);
        if (gv) prio = !g;
        @(negedge clock);
    endtask

    initial begin
        logic g;
        req_t idle;
        idle = mk(0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        prio = 1'b0; pend = 1'b0; pend_own = 1'b0; pend_data = '0;
        reset = 1'b1;
        drive(idle, idle, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_clear(DEPTH);

        for (int k = 0; k < 6; k++) begin
            run_cycle(mk(1, 0, 11'($urandom), 0, 0), mk(1, 0, 11'($urandom), 0, 0), 1'b0, g);
            chk("rr_seq", g, k[0]);
        end
        run_cycle(mk(1, 1, 11'h155, 8'hA5, 4'hF), idle, 1'b0, g);
        run_cycle(mk(1, 0, 11'h155, 8'h00, 4'h0), idle, 1'b0, g);
        chk("c0_rdata_a5", {c0_rvalid, c1_rvalid, c0_rdata}, {2'b10, 8'hA5});
        run_cycle(idle, mk(1, 1, 11'd7, 8'hFF, 4'hF), 1'b0, g);
        run_cycle(idle, mk(1, 1, 11'd7, 8'h00, 4'h5), 1'b0, g);
        run_cycle(idle, mk(1, 0, 11'd7, 8'h00, 4'h0), 1'b0, g);
        chk("masked_cc", {c1_rvalid, c1_rdata}, {1'b1, 8'hCC});
        run_cycle(idle, idle, 1'b0, g);
        for (int k = 0; k < 300; k++) run_cycle(rnd(), rnd(), 1'b0, g);

        // Clear request coinciding with an accepted read.
        run_cycle(mk(1, 0, 11'd3, 0, 0), mk(1, 0, 11'd3, 0, 0), 1'b1, g);
        check_clear(DEPTH);
        run_cycle(idle, idle, 1'b0, g);

        check_clear(0);
        clr_start = 1'b1;
        #1;
        @(negedge clock);
        check_clear(1000);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        prio = 1'b0;
        check_clear(DEPTH);
        for (int k = 0; k < 50; k++) run_cycle(rnd(), rnd(), 1'b0, g);

        // Reset while a read is being accepted drops its response.
        drive(mk(1, 0, 11'd5, 0, 0), idle, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pend = 1'b0;
        prio = 1'b0;
        check_clear(DEPTH);
        for (int k = 0; k < 30; k++) run_cycle(rnd(), rnd(), 1'b0, g);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
